// File: rtl/board_mem.sv
// board_mem: game board storage with VGA read port, game-logic write port, auto-clear and score counter
module board_mem #(
  parameter int DEPTH     = 1024,
  parameter int WIDTH     = 16,
  parameter int SCORE_MAX = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             re,
  input  logic [9:0]       raddr,
  output logic [WIDTH-1:0] state,
  input  logic             wvalid,
  input  logic [9:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic             wready,
  input  logic             clr,
  input  logic             inc_score,
  output logic [9:0]       score,
  output logic             busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, CLEAR} st_t;
  st_t st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [9:0] score_q, score_d;
  logic [WIDTH-1:0] state_q, rd_data;
  logic [WIDTH-1:0] mem [DEPTH];
  logic last, clr_we, usr_we;
  assign busy    = st_q == CLEAR;
  assign wready  = !busy;
  assign state   = state_q;
  assign score   = score_q;
  assign last    = cnt_q == AW'(DEPTH - 1);
  assign clr_we  = busy && !clr;
  assign usr_we  = wvalid && wready && (32'(waddr) < DEPTH);
  assign rd_data = (32'(raddr) < DEPTH) ? mem[raddr] : '0;
  // next state: clr (re)starts the sweep, otherwise sweep ascends until the last cell
  always_comb begin
    st_d    = clr ? CLEAR : (busy && last) ? IDLE : st_q;
    cnt_d   = (clr || !busy || last) ? '0 : cnt_q + AW'(1);
    score_d = clr ? '0 : (inc_score && score_q < 10'(SCORE_MAX)) ? score_q + 10'd1 : score_q;
  end
  // control registers; reset parks the sweep at address 0 so it runs right after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= CLEAR;
      cnt_q   <= '0;
      score_q <= '0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      state_q <= re ? rd_data : state_q;
    end
  end
  // single write port shared by the clear sweep and game logic (never both in one cycle)
  always_ff @(posedge clk) begin
    if (clr_we || usr_we) mem[clr_we ? cnt_q : waddr[AW-1:0]] <= clr_we ? '0 : wdata;
  end
endmodule

// File: tb/tb_board_mem.sv
// tb_board_mem: randomized scoreboard bench for board_mem against a behavioural model
module tb_board_mem;
  localparam int DEPTH = 1024;
  localparam int SMAX  = 999;
  logic clk = 0, reset = 1, re = 0, wvalid = 0, clr = 0, inc_score = 0;
  logic [9:0] raddr = '0, waddr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] state;
  logic [9:0] score;
  logic wready, busy;

  board_mem #(.DEPTH(DEPTH), .WIDTH(16), .SCORE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .re(re), .raddr(raddr), .state(state),
    .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wready(wready),
    .clr(clr), .inc_score(inc_score), .score(score), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] st;
    bit          chk;
    int          sc;
    bit          bz;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, ncyc = 0;

  logic [15:0] mmem [DEPTH];
  bit known [DEPTH];
  logic [15:0] m_state = '0;
  bit m_known = 1;
  int m_score = 0;
  int clr_rem = DEPTH;
  bit acc;

  always @(posedge clk) ncyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // monitor: compare every expectation due at the edge just passed
  always @(posedge clk) begin
    exp_t e;
    #2;
    while (q.size() > 0 && q[0].cyc == ncyc) begin
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.bz));
      chk("wready", 32'(wready), 32'(!e.bz));
      chk("score", 32'(score), e.sc);
      if (e.chk) chk("state", 32'(state), 32'(e.st));
    end
  end

  // model one clock edge with the current inputs, queue the expected outputs, advance
  task automatic step();
    exp_t e;
    bit was_busy;
    was_busy = clr_rem > 0;
    acc = 0;
    if (re) begin
      m_state = mmem[raddr];
      m_known = known[raddr];
    end
    if (clr) clr_rem = DEPTH;
    else if (clr_rem > 0) begin
      mmem[DEPTH - clr_rem] = '0;
      known[DEPTH - clr_rem] = 1;
      clr_rem--;
    end
    if (!was_busy && wvalid) begin
      mmem[waddr] = wdata;
      known[waddr] = 1;
      acc = 1;
    end
    if (clr) m_score = 0;
    else if (inc_score && m_score < SMAX) m_score++;
    e.cyc = ncyc + 1;
    e.st  = m_state;
    e.chk = m_known;
    e.sc  = m_score;
    e.bz  = clr_rem > 0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    re = 0; wvalid = 0; clr = 0; inc_score = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1;
    idle_inputs();
    m_state = '0; m_known = 1; m_score = 0; clr_rem = DEPTH;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_wready", 32'(wready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_busy", 32'(busy), 1);
    reset = 0;
  endtask

  task automatic rd(input int a);
    re = 1; raddr = 10'(a);
    step();
    re = 0;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wvalid = 1; waddr = 10'(a); wdata = d;
    step();
    wvalid = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 1200 && clr_rem > 0; n++) step();
    chk("clear_done", 32'(clr_rem), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; known[i] = 0; end
    do_reset();
    repeat (DEPTH) step();
    chk("post_clear_busy", 32'(busy), 0);
    chk("post_clear_wready", 32'(wready), 1);
    rd(0); rd(511); rd(1023);
    chk("rd1023", 32'(state), 0);
    wr(5, 16'hA5A5);
    rd(5);
    chk("rd5", 32'(state), 32'h0000A5A5);
    wr(7, 16'h1234);
    re = 1; raddr = 10'd7; wvalid = 1; waddr = 10'd7; wdata = 16'hBEEF;
    step();
    chk("rd7_old", 32'(state), 32'h00001234);
    idle_inputs();
    rd(7);
    chk("rd7_new", 32'(state), 32'h0000BEEF);
    for (int i = 0; i < 800; i++) begin
      re = 1'($urandom); raddr = 10'($urandom_range(0, 31));
      wvalid = 1'($urandom); waddr = 10'($urandom_range(0, 31)); wdata = 16'($urandom);
      inc_score = 1'($urandom); clr = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_inputs();
    wait_idle();
    clr = 1; step(); clr = 0;
    repeat (100) step();
    clr = 1; step(); clr = 0;
    chk("restart_score", 32'(score), 0);
    repeat (DEPTH - 1) step();
    chk("restart_busy_last", 32'(busy), 1);
    step();
    chk("restart_busy_end", 32'(busy), 0);
    inc_score = 1;
    repeat (1005) step();
    inc_score = 0;
    chk("score_sat", 32'(score), 999);
    clr = 1; inc_score = 1; step(); idle_inputs();
    chk("score_clr_wins", 32'(score), 0);
    wvalid = 1; waddr = 10'd9; wdata = 16'h7777;
    n = 0;
    acc = 0;
    while (!acc && n < 2000) begin step(); n++; end
    chk("held_write_accepted", 32'(acc), 1);
    chk("held_write_cycles", n, DEPTH + 1);
    wvalid = 0;
    rd(9);
    chk("rd9", 32'(state), 32'h00007777);
    wr(300, 16'h3030); wr(301, 16'h3131);
    clr = 1; step(); clr = 0;
    repeat (300) step();
    rd(301);
    chk("rd301_uncleared", 32'(state), 32'h00003131);
    do_reset();
    repeat (DEPTH - 1) step();
    chk("reset_clear_busy", 32'(busy), 1);
    step();
    chk("reset_clear_end", 32'(busy), 0);
    for (int i = 0; i < 20; i++) rd($urandom_range(0, DEPTH - 1));
    rd(301);
    chk("rd301_cleared", 32'(state), 0);
    repeat (2) @(posedge clk);
    #3;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
